// File: rtl/sisc_fetch_if.sv
// Instruction-memory read port between the SISC fetch unit and imem.
// The requester holds imem_req and imem_addr until imem_ack or its own timeout.
interface sisc_fetch_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 32
) ();
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/sisc_fetch_unit.sv
// SISC fetch unit: owns PC and IR, executes control-FSM commands and runs a
// req/ack instruction fetch with timeout, reporting busy/valid/error status.
module sisc_fetch_unit #(
  parameter int PC_W     = 16,
  parameter int INSTR_W  = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_rst,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  input  logic               ir_load,
  sisc_fetch_if.master       bus,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ir,
  output logic               fetch_busy,
  output logic               fetch_valid,
  output logic               fetch_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  // Branch offset is widened to at least 16 bits before truncation to PC_W.
  localparam int EXT_W = (PC_W > 16) ? PC_W : 16;

  typedef enum logic [1:0] {IDLE, REQ, DONE, TOUT} state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_next;
  logic [INSTR_W-1:0] ir_q;
  logic [PC_W-1:0]    addr_q;
  logic               req_q;
  logic               err_q;
  logic [CNT_W-1:0]   wait_cnt_q, cnt_inc;
  logic               start_fetch, take_ack, timeout, busy_load;
  logic [EXT_W-1:0]   br_rel_ext, br_abs_ext;

  assign br_rel_ext = EXT_W'($signed(ir_q[15:0]));
  assign br_abs_ext = EXT_W'(ir_q[15:0]);

  always_comb begin
    pc_next = pc_q;
    if (pc_rst)       pc_next = '0;
    else if (!pc_sel) pc_next = pc_q + PC_W'(1);
    else if (br_sel)  pc_next = br_abs_ext[PC_W-1:0];
    else              pc_next = pc_q + br_rel_ext[PC_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    start_fetch = 1'b0;
    take_ack    = 1'b0;
    timeout     = 1'b0;
    cnt_inc     = wait_cnt_q + CNT_W'(1);
    busy_load   = ir_load && (state_q != IDLE);
    case (state_q)
      IDLE: if (ir_load) begin
        start_fetch = 1'b1;
        state_d     = REQ;
      end
      REQ: begin
        if (bus.imem_ack) begin
          take_ack = 1'b1;
          state_d  = DONE;
        end else if (cnt_inc == CNT_W'(MAX_WAIT)) begin
          timeout = 1'b1;
          state_d = TOUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the branch target therefore sees the old IR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      ir_q       <= '0;
      addr_q     <= '0;
      req_q      <= 1'b0;
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      if (pc_write) pc_q <= pc_next;

      if (start_fetch) begin
        addr_q     <= pc_q;
        req_q      <= 1'b1;
        wait_cnt_q <= '0;
      end else if (state_q == REQ && !bus.imem_ack) begin
        wait_cnt_q <= cnt_inc;
      end

      if (take_ack) begin
        ir_q  <= bus.imem_rdata;
        req_q <= 1'b0;
      end else if (timeout) begin
        ir_q  <= '0;
        req_q <= 1'b0;
      end

      if (timeout || busy_load) err_q <= 1'b1;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign pc            = pc_q;
  assign ir            = ir_q;
  assign fetch_busy    = (state_q != IDLE);
  assign fetch_valid   = (state_q == DONE) || (state_q == TOUT);
  assign fetch_err     = err_q;

endmodule
